fp_add_sequencer: RTL and testbench
===================================

Name: fp_add_sequencer

Overview:
- Registered issue/capture stage wrapped around the combinational floating-point adder.
- Accepts IEEE-754 single-precision operand pairs plus an add/sub select over a valid/ready handshake, and drives the adder's para1/para2 from registers.
- Waits a fixed settle time, then captures the adder's out/under_overflow into a result FIFO.
- Presents results downstream over a valid/ready handshake, decoupling the untimed adder from the clocked datapath.

Parameters:
LATENCY, 1, cycles the adder inputs are held stable before sampling its result; legal range is 1 to 15.
DEPTH, 4, result FIFO entries; must be a power of two, 2 to 16.

Ports:
clk  input  1  clock; all logic rising-edge.
rst  input  1  synchronous active-high reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  sequencer can accept an operand pair.
in_a  input  32  operand A.
in_b  input  32  operand B.
in_sub  input  1  1 = compute A-B, 0 = A+B.
add_para1  output  32  registered operand to adder para1.
add_para2  output  32  registered operand to adder para2.
add_out  input  32  adder result.
add_under_overflow  input  1  adder under/overflow flag.
res_valid  output  1  FIFO head valid.
res_ready  input  1  downstream consumes head.
res_data  output  32  FIFO head result.
res_flag  output  1  FIFO head under/overflow flag.
busy  output  1  an operation is in flight (state is not IDLE).

Behaviour:
- One clock, synchronous active-high reset.
- Reset values:
  - All outputs are 0, except that in_ready is 1 from the first cycle after rst deasserts.
  - State is IDLE, the FIFO is empty, and FIFO storage is cleared.
- States:
  - IDLE: waiting for an operand pair.
  - EXEC: adder inputs held; runs LATENCY cycles.
  - BYPASS: one cycle; only exists with the optional feature.
- in_ready = !rst && state==IDLE && fifo_count<DEPTH (combinational). Only one operation is in flight, so an accepted operation always has a FIFO slot.
- Accept occurs when in_valid && in_ready in cycle T:
  - add_para1 <= in_a.
  - add_para2 <= {in_b[31]^in_sub, in_b[30:0]}.
  - The cycle counter loads LATENCY-1.
  - Next state is EXEC (or BYPASS, see Optional Feature).
- EXEC occupies cycles T+1 .. T+LATENCY:
  - The counter decrements each cycle.
  - On the cycle the counter reads 0, add_out and add_under_overflow are pushed into the FIFO at the closing edge, and the state returns to IDLE.
  - res_valid is first high in cycle T+LATENCY+1 when the FIFO was empty.
- Back-to-back: a new accept is possible in cycle T+LATENCY+1, so throughput is one operation per LATENCY+1 cycles.
- add_para1/add_para2 hold their value until the next accept; they are never changed mid-EXEC.
- Operands of accepted pairs are unconstrained.
- FIFO:
  - First-word-fall-through: res_data/res_flag show the head whenever res_valid=1.
  - Pop occurs when res_valid && res_ready.
  - Pointers wrap modulo DEPTH.
  - A simultaneous push and pop leaves the count unchanged, and the pushed entry lands behind the remaining entries; order is strict FIFO.
  - Pop while empty is ignored.
  - When empty, res_data/res_flag hold the last popped value (0 after reset).
- Full: in_ready=0 until a pop. A pop in cycle C makes in_ready=1 in cycle C+1.
- Reset asserted mid-EXEC or mid-BYPASS aborts the operation: no push occurs, the FIFO is emptied, and the state returns to IDLE.
- in_a/in_b/in_sub are ignored when not accepted.

Optional Feature:
FP_ADD_SEQ_BYPASS_EN:
- When defined, special operands (after the in_sub sign fix) are detected at accept. In this case the next state is BYPASS, the result is pushed at the end of cycle T+1, and the adder output is ignored. The rules are:
  - Either exponent==8'hFF: result 32'h7FC00000, flag 1.
  - Else, exactly one exponent==0: result is the other operand, flag 0.
  - Else, both exponents==0: result {signA&signB, 31'b0}, flag 0.
- add_para1/para2 are still loaded.
- When not defined, there is no BYPASS state and all pairs go through EXEC.

Test Plan:
- LATENCY=1: accept in_a=32'h3F800000, in_b=32'h40000000, in_sub=0 in cycle 0 with add_out modelled as 32'h40400000. Required: add_para2=32'h40000000 in cycle 1; res_valid=1, res_data=32'h40400000, res_flag=0 in cycle 2; in_ready=1 in cycle 2.
- in_a=32'h40400000, in_b=32'h3F800000, in_sub=1. Required: add_para2=32'hBF800000; the result equals the modelled add_out 32'h40000000.
- in_a=in_b=32'h7F7FFFFF, with the model driving 32'h7F800000 and flag 1. Required: res_data=32'h7F800000, res_flag=1.
- DEPTH=2, res_ready=0, three operations offered. Required: two are accepted, then in_ready stays 0. After one pop, the third is accepted, and results emerge in order.
- rst pulsed in cycle 1 of LATENCY=3 EXEC with FIFO holding 1 entry. Required: res_valid=0, busy=0, and no result is pushed after release.
- With FP_ADD_SEQ_BYPASS_EN, run two cases:
  - 32'h00000000 + 32'h40400000 gives 32'h40400000, flag 0, res_valid in cycle 2, regardless of add_out.
  - 32'h7FC00000 + 32'h3F800000 gives 32'h7FC00000, flag 1.

Source files
------------

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: registered issue/capture stage around a combinational
// single-precision adder. Operands are latched onto add_para1/add_para2, held
// for LATENCY cycles, then add_out/add_under_overflow are captured into a
// first-word-fall-through result FIFO.
// Optional feature macro: FP_ADD_SEQ_BYPASS_EN (special-operand bypass).
//
// Handshakes (both ports): a transfer happens on a rising edge where
// valid && ready are both high. The source holds its payload while valid is
// high, and ready may depend combinationally on sequencer state only.
module fp_add_sequencer #(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    output logic [31:0] add_para1,
    output logic [31:0] add_para2,
    input  logic [31:0] add_out,
    input  logic        add_under_overflow,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_flag,
    output logic        busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_BYPASS = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   para1_q, para1_d;
    logic [31:0]   para2_q, para2_d;
    logic [32:0]   mem_q [DEPTH];
    logic [32:0]   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [32:0]   last_q, last_d;

    logic          accept;
    logic          push;
    logic          pop;
    logic [32:0]   push_word;
    logic [31:0]   b_fix;

    // Subtraction is folded into operand B by flipping its sign bit.
    assign b_fix  = {in_b[31] ^ in_sub, in_b[30:0]};

    assign in_ready  = !rst && (state_q == S_IDLE) && (count_q < CW'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign res_valid = (count_q != '0);
    assign pop       = res_valid && res_ready;
    assign add_para1 = para1_q;
    assign add_para2 = para2_q;
    assign busy      = (state_q != S_IDLE);
    // Head shows through when non-empty; otherwise the last popped entry.
    assign res_data  = res_valid ? mem_q[rd_ptr_q][31:0] : last_q[31:0];
    assign res_flag  = res_valid ? mem_q[rd_ptr_q][32]   : last_q[32];

`ifdef FP_ADD_SEQ_BYPASS_EN
    logic [32:0] byp_q, byp_d;
    logic        special;
    logic [32:0] special_res;

    // Classify special operands (NaN/Inf or zero/denormal exponents) at accept.
    always_comb begin
        special     = 1'b1;
        special_res = 33'd0;
        if (in_a[30:23] == 8'hFF || b_fix[30:23] == 8'hFF) begin
            special_res = {1'b1, 32'h7FC0_0000};
        end else if (in_a[30:23] == 8'h00 && b_fix[30:23] == 8'h00) begin
            special_res = {1'b0, in_a[31] & b_fix[31], 31'd0};
        end else if (in_a[30:23] == 8'h00) begin
            special_res = {1'b0, b_fix};
        end else if (b_fix[30:23] == 8'h00) begin
            special_res = {1'b0, in_a};
        end else begin
            special = 1'b0;
        end
    end
`endif

    // Sequencer FSM: next state, operand registers, settle counter, push request.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        para1_d   = para1_q;
        para2_d   = para2_q;
        push      = 1'b0;
        push_word = 33'd0;
`ifdef FP_ADD_SEQ_BYPASS_EN
        byp_d     = byp_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    para1_d = in_a;
                    para2_d = b_fix;
                    cnt_d   = 4'(LATENCY - 1);
`ifdef FP_ADD_SEQ_BYPASS_EN
                    if (special) begin
                        state_d = S_BYPASS;
                        byp_d   = special_res;
                    end else begin
                        state_d = S_EXEC;
                    end
`else
                    state_d = S_EXEC;
`endif
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    push      = 1'b1;
                    push_word = {add_under_overflow, add_out};
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_BYPASS: begin
`ifdef FP_ADD_SEQ_BYPASS_EN
                push      = 1'b1;
                push_word = byp_q;
`endif
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result FIFO: pointer/count update, storage write and last-popped capture.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_word;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            last_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // State register; reset aborts any in-flight operation and clears the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            para1_q  <= 32'd0;
            para2_q  <= 32'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= 33'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 33'd0;
            end
`ifdef FP_ADD_SEQ_BYPASS_EN
            byp_q    <= 33'd0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            para1_q  <= para1_d;
            para2_q  <= para2_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
`ifdef FP_ADD_SEQ_BYPASS_EN
            byp_q    <= byp_d;
`endif
        end
    end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Testbench for fp_add_sequencer: directed vectors, scoreboard queue of
// expected {flag,data} results, monitor popping on each result transfer.
// Main instance: LATENCY=1, DEPTH=2. Second instance: LATENCY=3, DEPTH=4.
module tb_fp_add_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, in_sub;
    logic [31:0] in_a, in_b, add_para1, add_para2, add_out, res_data;
    logic        add_uo, res_valid, res_ready, res_flag, busy;

    logic        rst_3;
    logic        in_valid_3, in_ready_3, in_sub_3;
    logic [31:0] in_a_3, in_b_3, add_para1_3, add_para2_3, add_out_3, res_data_3;
    logic        add_uo_3, res_valid_3, res_ready_3, res_flag_3, busy_3;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] exp_q[$];

    fp_add_sequencer #(.LATENCY(1), .DEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .add_para1(add_para1), .add_para2(add_para2),
        .add_out(add_out), .add_under_overflow(add_uo),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flag(res_flag), .busy(busy)
    );

    fp_add_sequencer #(.LATENCY(3), .DEPTH(4)) u_dut_l3 (
        .clk(clk), .rst(rst_3), .in_valid(in_valid_3), .in_ready(in_ready_3),
        .in_a(in_a_3), .in_b(in_b_3), .in_sub(in_sub_3),
        .add_para1(add_para1_3), .add_para2(add_para2_3),
        .add_out(add_out_3), .add_under_overflow(add_uo_3),
        .res_valid(res_valid_3), .res_ready(res_ready_3),
        .res_data(res_data_3), .res_flag(res_flag_3), .busy(busy_3)
    );

    // Stub adder: only the directed operand pairs give meaningful sums.
    function automatic logic [32:0] adder_model(input logic [31:0] p1, input logic [31:0] p2);
        case ({p1, p2})
            {32'h3F80_0000, 32'h4000_0000}: adder_model = {1'b0, 32'h4040_0000};
            {32'h4040_0000, 32'hBF80_0000}: adder_model = {1'b0, 32'h4000_0000};
            {32'h7F7F_FFFF, 32'h7F7F_FFFF}: adder_model = {1'b1, 32'h7F80_0000};
            {32'h4000_0000, 32'h4000_0000}: adder_model = {1'b0, 32'h4080_0000};
            {32'h4080_0000, 32'h4080_0000}: adder_model = {1'b0, 32'h4100_0000};
            {32'h4100_0000, 32'h4100_0000}: adder_model = {1'b0, 32'h4180_0000};
            default:                        adder_model = {1'b0, 32'hDEAD_BEEF};
        endcase
    endfunction

    always_comb {add_uo, add_out}     = adder_model(add_para1, add_para2);
    always_comb {add_uo_3, add_out_3} = adder_model(add_para1_3, add_para2_3);

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every result transfer is compared against the queue head.
    always @(negedge clk) begin
        if (!rst && res_valid === 1'b1 && res_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %h expected none", {res_flag, res_data});
            end else begin
                check("result", {res_flag, res_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one operand pair; record its expected result when it is accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [32:0] e);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = s;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: got in_ready=0 expected accept of %h/%h", a, b);
        in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; res_ready = 1'b1;
        rst_3 = 1'b1; in_valid_3 = 1'b0; in_a_3 = '0; in_b_3 = '0; in_sub_3 = 1'b0;
        res_ready_3 = 1'b0;

        step(2);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_para1", add_para1, 0);
        check("rst_para2", add_para2, 0);
        check("rst_res_data", {res_flag, res_data}, 0);
        @(posedge clk); #1;
        rst = 1'b0; rst_3 = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);
        @(posedge clk); #1;

        // 1.0 + 2.0, latency and handshake timing
        send(32'h3F80_0000, 32'h4000_0000, 1'b0, {1'b0, 32'h4040_0000});
        @(negedge clk);
        check("t1_para1", add_para1, 32'h3F80_0000);
        check("t1_para2", add_para2, 32'h4000_0000);
        check("t1_busy", busy, 1);
        check("t1_in_ready_exec", in_ready, 0);
        @(negedge clk);
        check("t1_res_valid_c2", res_valid, 1);
        check("t1_res_data_c2", {res_flag, res_data}, {1'b0, 32'h4040_0000});
        check("t1_in_ready_c2", in_ready, 1);
        @(posedge clk); #1;

        // 3.0 - 1.0: sign of B flipped onto para2
        send(32'h4040_0000, 32'h3F80_0000, 1'b1, {1'b0, 32'h4000_0000});
        @(negedge clk);
        check("t2_para2_signfix", add_para2, 32'hBF80_0000);
        step(2);

        // overflow flag propagation
        send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, {1'b1, 32'h7F80_0000});
        step(3);

        // DEPTH=2 full: third pair waits until one pop
        res_ready = 1'b0;
        send(32'h4000_0000, 32'h4000_0000, 1'b0, {1'b0, 32'h4080_0000});
        send(32'h4080_0000, 32'h4080_0000, 1'b0, {1'b0, 32'h4100_0000});
        in_valid = 1'b1; in_a = 32'h4100_0000; in_b = 32'h4100_0000; in_sub = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_in_ready_low", in_ready, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("full_head_fwft", {res_flag, res_data}, {1'b0, 32'h4080_0000});
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("in_ready_after_pop", in_ready, 1);
        if (in_ready) exp_q.push_back({1'b0, 32'h4180_0000});
        @(posedge clk); #1;
        in_valid = 1'b0;
        step(3);
        res_ready = 1'b1;
        step(4);
        @(negedge clk);
        check("empty_res_valid", res_valid, 0);
        check("empty_holds_last", {res_flag, res_data}, {1'b0, 32'h4180_0000});
        @(posedge clk); #1;

`ifdef FP_ADD_SEQ_BYPASS_EN
        // zero operand: other operand returned, adder output ignored
        send(32'h0000_0000, 32'h4040_0000, 1'b0, {1'b0, 32'h4040_0000});
        @(negedge clk);
        check("byp_busy_c1", busy, 1);
        @(negedge clk);
        check("byp_res_valid_c2", res_valid, 1);
        @(posedge clk); #1;
        // NaN operand: canonical quiet NaN with flag
        send(32'h7FC0_0000, 32'h3F80_0000, 1'b0, {1'b1, 32'h7FC0_0000});
        step(3);
`endif

        // LATENCY=3 instance: first result timing, then reset mid-EXEC
        in_valid_3 = 1'b1; in_a_3 = 32'h3F80_0000; in_b_3 = 32'h4000_0000;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready_3) break;
        end
        @(posedge clk); #1;
        in_valid_3 = 1'b0;
        repeat (3) @(negedge clk);
        check("l3_res_valid_c3", res_valid_3, 0);
        @(negedge clk);
        check("l3_res_valid_c4", res_valid_3, 1);
        check("l3_res_data", {res_flag_3, res_data_3}, {1'b0, 32'h4040_0000});
        @(posedge clk); #1;
        in_valid_3 = 1'b1; in_a_3 = 32'h4000_0000; in_b_3 = 32'h4000_0000;
        @(negedge clk);
        check("l3_second_ready", in_ready_3, 1);
        @(posedge clk); #1;
        in_valid_3 = 1'b0;
        rst_3 = 1'b1;
        @(negedge clk);
        check("l3_busy_in_exec", busy_3, 1);
        check("l3_in_ready_in_rst", in_ready_3, 0);
        @(posedge clk); #1;
        rst_3 = 1'b0;
        @(negedge clk);
        check("abort_res_valid", res_valid_3, 0);
        check("abort_busy", busy_3, 0);
        check("abort_res_data", {res_flag_3, res_data_3}, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_push", res_valid_3, 0);
        end
        check("abort_in_ready", in_ready_3, 1);

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
